capture_sequencer: RTL and testbench

Arms, triggers and stops the logic-capture datapath. Holds the capture block idle until a host arm command, watches the probe bus for a programmable pattern/edge trigger, then enables capture for a fixed number of BRAM writes and reports completion. Sits between the host register file and the capture block's `control` input, and monitors that block's `we` strobe.

---
 rtl/capture_sequencer.sv | 151 +++++++++++++++
 tb/tb_capture_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on a host command, waits for a pattern/edge trigger,
// runs the capture block for a fixed number of BRAM writes, then reports done.
module capture_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 18,
    parameter int TMO_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       host_ctrl,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] rise_mask,
    input  logic [DATA_W-1:0] fall_mask,
    input  logic [ADDR_W-1:0] post_count,
    input  logic [TMO_W-1:0]  trig_timeout,
    input  logic [DATA_W-1:0] datain,
    input  logic              cap_we,
    output logic [31:0]       cap_control,
    output logic [31:0]       status,
    output logic              done_irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t             state_reg;
    logic [DATA_W-1:0]  d0_reg, d1_reg;
    logic               arm_prev_reg;
    logic               run_reg;
    logic               irq_reg;
    logic               triggered_reg;
    logic               timeout_reg;
    logic               aborted_reg;
    logic               done_reg;
    logic [ADDR_W:0]    count_reg;
    logic [TMO_W-1:0]   tmo_count_reg;

    logic [DATA_W-1:0]  pat_miss;
    logic [DATA_W-1:0]  edge_hit;
    logic               edge_ok, hit, arm_edge, abort, tmo_expired;
    logic [ADDR_W:0]    target, count_next;
    logic               unused_ctrl;

    // Per-channel compare against the newest sample (d1) and its predecessor (d0).
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_chan
            assign pat_miss[gi] = (d1_reg[gi] ^ trig_value[gi]) & trig_mask[gi];
            assign edge_hit[gi] = ( d1_reg[gi] & ~d0_reg[gi] & rise_mask[gi]) |
                                  (~d1_reg[gi] &  d0_reg[gi] & fall_mask[gi]);
        end
    endgenerate

    assign edge_ok     = ((rise_mask | fall_mask) == '0) | (|edge_hit);
    assign hit         = ~(|pat_miss) & edge_ok;
    assign arm_edge    = host_ctrl[0] & ~arm_prev_reg;
    assign abort       = host_ctrl[1];
    assign tmo_expired = (trig_timeout != '0) && (tmo_count_reg == trig_timeout);
    assign target      = (post_count == '0) ? FULL_DEPTH : {1'b0, post_count};
    assign count_next  = count_reg + COUNT_ONE;
    assign unused_ctrl = ^host_ctrl[31:2];

    assign cap_control = {31'b0, run_reg};
    assign done_irq    = irq_reg;

    always_comb begin
        status               = '0;
        status[1:0]          = state_reg;
        status[2]            = triggered_reg;
        status[3]            = timeout_reg;
        status[4]            = aborted_reg;
        status[5]            = done_reg;
        status[ADDR_W+8:8]   = count_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            d0_reg        <= '0;
            d1_reg        <= '0;
            arm_prev_reg  <= 1'b0;
            run_reg       <= 1'b0;
            irq_reg       <= 1'b0;
            triggered_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            aborted_reg   <= 1'b0;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            tmo_count_reg <= '0;
        end else begin
            d1_reg       <= datain;
            d0_reg       <= d1_reg;
            arm_prev_reg <= host_ctrl[0];
            irq_reg      <= 1'b0;
            // Abort outranks everything, including an arm edge in the same cycle.
            if (abort) begin
                state_reg   <= IDLE;
                aborted_reg <= 1'b1;
                run_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (arm_edge) begin
                            state_reg     <= ARMED;
                            triggered_reg <= 1'b0;
                            timeout_reg   <= 1'b0;
                            aborted_reg   <= 1'b0;
                            done_reg      <= 1'b0;
                            count_reg     <= '0;
                            tmo_count_reg <= '0;
                        end
                    end
                    ARMED: begin
                        if (hit) begin
                            state_reg     <= RUN;
                            triggered_reg <= 1'b1;
                            run_reg       <= 1'b1;
                        end else if (tmo_expired) begin
                            state_reg   <= DONE;
                            timeout_reg <= 1'b1;
                            done_reg    <= 1'b1;
                            irq_reg     <= 1'b1;
                        end else if (tmo_count_reg != '1) begin
                            tmo_count_reg <= tmo_count_reg + TMO_ONE;
                        end
                    end
                    RUN: begin
                        if (cap_we) begin
                            count_reg <= count_next;
                            if (count_next == target) begin
                                state_reg <= DONE;
                                run_reg   <= 1'b0;
                                done_reg  <= 1'b1;
                                irq_reg   <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_capture_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TW = 32;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   host_ctrl;
    logic [DW-1:0] trig_mask, trig_value, rise_mask, fall_mask, datain;
    logic [AW-1:0] post_count;
    logic [TW-1:0] trig_timeout;
    logic          cap_we;
    logic [31:0]   cap_control, status;
    logic          done_irq;

    capture_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TMO_W(TW)) dut (
        .clk(clk), .reset(reset), .host_ctrl(host_ctrl),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .rise_mask(rise_mask), .fall_mask(fall_mask),
        .post_count(post_count), .trig_timeout(trig_timeout),
        .datain(datain), .cap_we(cap_we),
        .cap_control(cap_control), .status(status), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int irq_cnt = 0;

    // Reference model state: named phases, counts as plain integers, probe history.
    int      m_state;
    bit      m_trig, m_tmo, m_abrt, m_done, m_irq;
    int      m_count;
    longint  m_wait;
    bit [7:0] m_new, m_old;
    bit      m_arm_prev;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_state = M_IDLE; m_trig = 0; m_tmo = 0; m_abrt = 0; m_done = 0; m_irq = 0;
        m_count = 0; m_wait = 0; m_new = 0; m_old = 0; m_arm_prev = 0;
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(m_count) << 8) | (32'(m_done) << 5) | (32'(m_abrt) << 4) |
               (32'(m_tmo) << 3) | (32'(m_trig) << 2) | 32'(m_state);
    endfunction

    function automatic void model_step();
        bit arm_edge, pat_ok, edge_any, hit;
        int tgt;
        arm_edge = host_ctrl[0] && !m_arm_prev;
        pat_ok = 1;
        edge_any = 0;
        for (int i = 0; i < DW; i++) begin
            if (trig_mask[i] && (m_new[i] != trig_value[i])) pat_ok = 0;
            if (rise_mask[i] && m_new[i] && !m_old[i]) edge_any = 1;
            if (fall_mask[i] && !m_new[i] && m_old[i]) edge_any = 1;
        end
        hit = pat_ok && ((rise_mask == 0 && fall_mask == 0) || edge_any);
        tgt = (post_count == 0) ? (1 << AW) : int'(post_count);
        m_irq = 0;
        if (host_ctrl[1]) begin
            m_state = M_IDLE;
            m_abrt = 1;
        end else if (m_state == M_IDLE || m_state == M_DONE) begin
            if (arm_edge) begin
                m_state = M_ARMED;
                m_trig = 0; m_tmo = 0; m_abrt = 0; m_done = 0; m_count = 0; m_wait = 0;
            end
        end else if (m_state == M_ARMED) begin
            if (hit) begin
                m_state = M_RUN;
                m_trig = 1;
            end else if (trig_timeout != 0 && m_wait == longint'(trig_timeout)) begin
                m_state = M_DONE;
                m_tmo = 1; m_done = 1; m_irq = 1;
            end else if (m_wait < 64'hFFFF_FFFF) begin
                m_wait++;
            end
        end else if (cap_we) begin
            m_count++;
            if (m_count == tgt) begin
                m_state = M_DONE;
                m_done = 1; m_irq = 1;
            end
        end
        m_old = m_new;
        m_new = datain;
        m_arm_prev = host_ctrl[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cap_control", cap_control, {31'b0, m_state == M_RUN});
        check("status", status, m_status());
        check("done_irq", {31'b0, done_irq}, {31'b0, m_irq});
        if (done_irq) irq_cnt++;
    endtask

    task automatic set_cfg(input logic [7:0] tm, tv, rm, fm, input logic [AW-1:0] pc,
                           input logic [TW-1:0] to);
        trig_mask = tm; trig_value = tv; rise_mask = rm; fall_mask = fm;
        post_count = pc; trig_timeout = to;
    endtask

    typedef struct {
        logic [1:0]  hc;
        logic [7:0]  din;
        logic        we;
        logic [31:0] st;
        logic        run;
        logic        irq;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Pattern trigger, two-write capture, re-arm, abort and arm/abort collision.
        vecs[0]  = '{2'b00, 8'h00, 1'b0, 32'h000, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 8'h00, 1'b0, 32'h001, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 8'h00, 1'b0, 32'h001, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 8'hA5, 1'b0, 32'h001, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 8'hA5, 1'b0, 32'h006, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 8'hA5, 1'b1, 32'h106, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 8'hA5, 1'b0, 32'h106, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 8'hA5, 1'b1, 32'h227, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 8'hA5, 1'b1, 32'h227, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 8'hA5, 1'b0, 32'h001, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 8'hA5, 1'b0, 32'h006, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 8'hA5, 1'b0, 32'h014, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 8'hA5, 1'b0, 32'h014, 1'b0, 1'b0};
        vecs[13] = '{2'b00, 8'hA5, 1'b0, 32'h014, 1'b0, 1'b0};
        vecs[14] = '{2'b11, 8'hA5, 1'b0, 32'h014, 1'b0, 1'b0};
        vecs[15] = '{2'b01, 8'hA5, 1'b0, 32'h014, 1'b0, 1'b0};
        vecs[16] = '{2'b00, 8'hA5, 1'b1, 32'h014, 1'b0, 1'b0};

        reset = 1'b1; host_ctrl = '0; datain = '0; cap_we = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, '0, '0);
        m_reset();
        #12;
        check("reset_cap_control", cap_control, 32'h0);
        check("reset_status", status, 32'h0);
        check("reset_done_irq", {31'b0, done_irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        set_cfg(8'h0F, 8'h05, 8'h00, 8'h00, 4'd2, '0);
        for (int v = 0; v < 17; v++) begin
            host_ctrl = {30'b0, vecs[v].hc};
            datain = vecs[v].din;
            cap_we = vecs[v].we;
            tick();
            $display("[TB] vec %0d hc=%b din=%h we=%b -> status=%h run=%b irq=%b",
                     v, vecs[v].hc, vecs[v].din, vecs[v].we, status, cap_control[0], done_irq);
            check("vec_status", status, vecs[v].st);
            check("vec_run", {31'b0, cap_control[0]}, {31'b0, vecs[v].run});
            check("vec_irq", {31'b0, done_irq}, {31'b0, vecs[v].irq});
        end
        cap_we = 1'b0;

        // Falling-edge trigger on bit 7, three writes.
        set_cfg(8'h00, 8'h00, 8'h00, 8'h80, 4'd3, '0);
        host_ctrl = 0; datain = 8'h80;
        tick(); tick();
        host_ctrl = 1; tick();
        host_ctrl = 0; tick();
        check("edge_armed", {30'b0, status[1:0]}, 32'd1);
        irq_cnt = 0;
        datain = 8'h00; tick(); tick();
        check("edge_run", {30'b0, status[1:0]}, 32'd2);
        for (int p = 1; p <= 3; p++) begin
            cap_we = 1'b1; tick();
            cap_we = 1'b0;
            if (p == 3) begin
                check("edge_done_state", {30'b0, status[1:0]}, 32'd3);
                check("edge_done_count", 32'(status[AW+8:8]), 32'd3);
                check("edge_done_irq", {31'b0, done_irq}, 32'd1);
                check("edge_done_run", cap_control, 32'd0);
            end
            tick();
        end
        check("edge_irq_count", irq_cnt, 32'd1);
        $display("[TB] edge trigger capture status=%h", status);

        // Trigger timeout with a pattern that never matches.
        set_cfg(8'hFF, 8'hAA, 8'h00, 8'h00, 4'd1, 32'd10);
        datain = 8'h00; tick();
        host_ctrl = 1; tick();
        host_ctrl = 0;
        repeat (10) tick();
        check("tmo_still_armed", {30'b0, status[1:0]}, 32'd1);
        tick();
        check("tmo_done", {30'b0, status[1:0]}, 32'd3);
        check("tmo_flag", {31'b0, status[3]}, 32'd1);
        check("tmo_not_trig", {31'b0, status[2]}, 32'd0);
        check("tmo_irq", {31'b0, done_irq}, 32'd1);
        $display("[TB] timeout status=%h", status);

        // Abort in RUN after two writes.
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 4'd5, '0);
        irq_cnt = 0;
        host_ctrl = 1; tick();
        host_ctrl = 0; tick();
        repeat (2) begin
            cap_we = 1'b1; tick();
            cap_we = 1'b0; tick();
        end
        host_ctrl = 2; tick();
        check("abort_idle", {30'b0, status[1:0]}, 32'd0);
        check("abort_count", 32'(status[AW+8:8]), 32'd2);
        check("abort_flag", {31'b0, status[4]}, 32'd1);
        check("abort_run", cap_control, 32'd0);
        host_ctrl = 0; tick();
        check("abort_no_irq", irq_cnt, 32'd0);
        $display("[TB] abort in RUN status=%h", status);

        // Full depth: post_count 0 means 16 writes.
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 4'd0, '0);
        host_ctrl = 1; tick();
        host_ctrl = 0; tick();
        for (int p = 1; p <= 16; p++) begin
            cap_we = 1'b1; tick();
            cap_we = 1'b0;
            if (p == 15) check("full_15_run", {30'b0, status[1:0]}, 32'd2);
            if (p == 16) begin
                check("full_16_done", {30'b0, status[1:0]}, 32'd3);
                check("full_16_count", 32'(status[AW+8:8]), 32'd16);
            end
            tick();
        end
        $display("[TB] full depth status=%h", status);

        // Asynchronous reset in the middle of RUN.
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 4'd5, '0);
        host_ctrl = 1; tick();
        host_ctrl = 0; tick();
        cap_we = 1'b1; tick();
        cap_we = 1'b0;
        #2 reset = 1'b1;
        m_reset();
        #1;
        check("rst_cap_control", cap_control, 32'h0);
        check("rst_status", status, 32'h0);
        check("rst_done_irq", {31'b0, done_irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            cap_we = 1'b1; tick();
            check("idle_we_count", status, 32'h0);
        end
        cap_we = 1'b0;
        $display("[TB] reset mid-run status=%h", status);

        // Randomized traffic; configuration only changes outside ARMED/RUN.
        for (int c = 0; c < 4000; c++) begin
            if ((m_state == M_IDLE || m_state == M_DONE) && $urandom_range(0, 3) == 0)
                set_cfg(8'($urandom & $urandom), 8'($urandom),
                        ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom),
                        ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom),
                        4'($urandom_range(0, 15)), 32'($urandom_range(0, 20)));
            if ($urandom_range(0, 4) == 0) host_ctrl[0] = ~host_ctrl[0];
            host_ctrl[1] = ($urandom_range(0, 59) == 0);
            cap_we = host_ctrl[1] ? 1'b0 : 1'($urandom_range(0, 1));
            datain = ($urandom_range(0, 3) == 0) ? 8'($urandom) : datain;
            tick();
            if (m_irq) $display("[TB] random capture done at cycle %0d status=%h", c, status);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
